// File: rtl/pedal_pkg.sv
// Shared types and arithmetic helpers for the pedal effect core.
package pedal_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_CLIP   = 2'd1,
        MODE_TREM   = 2'd2,
        MODE_CRUSH  = 2'd3
    } mode_e;

    localparam int GAIN_W = 9;

    function automatic logic signed [31:0] sat_w(
        input logic signed [31:0] x,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic logic signed [31:0] clamp(
        input logic signed [31:0] x,
        input logic signed [31:0] t
    );
        if (x > t)
            return t;
        else if (x < -t)
            return -t;
        else
            return x;
    endfunction

endpackage

// File: rtl/pedal_lfo.sv
// Tremolo phase accumulator with an 8-bit unsigned triangle output.
module pedal_lfo
    import pedal_pkg::*;
#(
    parameter int LFO_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  logic [3:0] rate,
    output logic [7:0] lfo_tri
);

    logic [LFO_W-1:0] phase_q;
    logic [LFO_W-1:0] phase_d;
    logic [7:0]       ramp;

    always_comb begin
        phase_d = phase_q;
        if (adv)
            phase_d = phase_q + {{(LFO_W-4){1'b0}}, rate}
                    + {{(LFO_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            phase_q <= '0;
        else
            phase_q <= phase_d;
    end

    // Upper half of the cycle mirrors the ramp to form a triangle.
    assign ramp    = phase_q[LFO_W-2 -: 8];
    assign lfo_tri = phase_q[LFO_W-1] ? ~ramp : ramp;

endmodule

// File: rtl/pedal_fx_core.sv
// Guitar-pedal effect pipeline: bypass, hard clip, tremolo, bitcrush.
// Optional echo stage compiled in with PEDAL_ECHO_EN.
module pedal_fx_core
    import pedal_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int LFO_W       = 16,
    parameter int DELAY_DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic [1:0]               mode,
    input  logic [3:0]               level,
    input  logic [3:0]               rate,
    input  logic                     echo_on,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample
);

    localparam int PW = DATA_W + 10;

    logic       acc;
    logic [7:0] lfo_tri;

    assign acc = in_valid & ena;

    pedal_lfo #(.LFO_W(LFO_W)) u_lfo (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (acc),
        .rate    (rate),
        .lfo_tri (lfo_tri)
    );

    logic                     s1_v_q,    s1_v_d;
    logic signed [DATA_W-1:0] s1_smp_q,  s1_smp_d;
    mode_e                    s1_mode_q, s1_mode_d;
    logic [3:0]               s1_lvl_q,  s1_lvl_d;
    logic [7:0]               s1_tri_q,  s1_tri_d;
    logic                     s1_echo_q, s1_echo_d;

    always_comb begin
        s1_v_d    = acc;
        s1_smp_d  = s1_smp_q;
        s1_mode_d = s1_mode_q;
        s1_lvl_d  = s1_lvl_q;
        s1_tri_d  = s1_tri_q;
        s1_echo_d = s1_echo_q;
        if (acc) begin
            s1_smp_d  = in_sample;
            s1_mode_d = mode_e'(mode);
            s1_lvl_d  = level;
            s1_tri_d  = lfo_tri;
            s1_echo_d = echo_on;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_smp_q  <= '0;
            s1_mode_q <= MODE_BYPASS;
            s1_lvl_q  <= '0;
            s1_tri_q  <= '0;
            s1_echo_q <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_smp_q  <= s1_smp_d;
            s1_mode_q <= s1_mode_d;
            s1_lvl_q  <= s1_lvl_d;
            s1_tri_q  <= s1_tri_d;
            s1_echo_q <= s1_echo_d;
        end
    end

    logic signed [31:0]       x;
    logic signed [31:0]       lv;
    logic signed [31:0]       thr;
    logic signed [31:0]       clip_v;
    logic [11:0]              tl;
    logic [GAIN_W-1:0]        gain;
    logic signed [PW-1:0]     prod;
    int                       crush_c;
    logic [DATA_W-1:0]        mask;
    logic signed [DATA_W-1:0] fx;

    always_comb begin
        x      = {{(32-DATA_W){s1_smp_q[DATA_W-1]}}, s1_smp_q};
        lv     = {28'd0, s1_lvl_q};
        thr    = ((lv + 32'sd1) <<< (DATA_W - 5)) - 32'sd1;
        clip_v = clamp(x, thr);
        tl     = {4'd0, s1_tri_q} * {8'd0, s1_lvl_q};
        gain   = 9'd256 - GAIN_W'(tl >> 4);
        prod   = $signed({{10{s1_smp_q[DATA_W-1]}}, s1_smp_q})
               * $signed({{(PW-GAIN_W){1'b0}}, gain});
        crush_c = (lv > DATA_W - 1) ? DATA_W - 1 : int'(lv);
        mask   = ~(({{(DATA_W-1){1'b0}}, 1'b1} << crush_c)
               - {{(DATA_W-1){1'b0}}, 1'b1});
        fx     = s1_smp_q;
        unique case (s1_mode_q)
            MODE_CLIP:  fx = DATA_W'(clip_v);
            MODE_TREM:  fx = DATA_W'(prod >>> 8);
            MODE_CRUSH: fx = s1_smp_q & mask;
            default:    fx = s1_smp_q;
        endcase
    end

    logic                     out_valid_q,  out_valid_d;
    logic signed [DATA_W-1:0] out_sample_q, out_sample_d;

`ifdef PEDAL_ECHO_EN
    localparam int AW = $clog2(DELAY_DEPTH);

    logic                     s2_v_q,    s2_v_d;
    logic signed [DATA_W-1:0] s2_fx_q,   s2_fx_d;
    logic                     s2_echo_q, s2_echo_d;
    logic [AW-1:0]            wr_ptr_q,  wr_ptr_d;
    logic [AW:0]              fill_q,    fill_d;
    logic signed [DATA_W-1:0] mem_q [DELAY_DEPTH];
    logic signed [31:0]       fx32;
    logic signed [31:0]       dly32;
    logic signed [31:0]       fb32;
    logic signed [31:0]       mix32;

    always_comb begin
        s2_v_d    = s1_v_q;
        s2_fx_d   = s1_v_q ? fx : s2_fx_q;
        s2_echo_d = s1_v_q ? s1_echo_q : s2_echo_q;
        fx32      = {{(32-DATA_W){s2_fx_q[DATA_W-1]}}, s2_fx_q};
        dly32     = '0;
        // Unwritten RAM reads as silence until one full lap is stored.
        if (fill_q[AW])
            dly32 = {{(32-DATA_W){mem_q[wr_ptr_q][DATA_W-1]}},
                     mem_q[wr_ptr_q]};
        fb32  = sat_w(fx32 + (dly32 >>> 2), DATA_W);
        mix32 = sat_w(fx32 + (dly32 >>> 1), DATA_W);
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        out_valid_d  = s2_v_q;
        out_sample_d = out_sample_q;
        if (s2_v_q) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            fill_d       = fill_q[AW] ? fill_q : fill_q + 1'b1;
            out_sample_d = s2_echo_q ? DATA_W'(mix32) : s2_fx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (s2_v_q)
            mem_q[wr_ptr_q] <= DATA_W'(fb32);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v_q    <= 1'b0;
            s2_fx_q   <= '0;
            s2_echo_q <= 1'b0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
        end else begin
            s2_v_q    <= s2_v_d;
            s2_fx_q   <= s2_fx_d;
            s2_echo_q <= s2_echo_d;
            wr_ptr_q  <= wr_ptr_d;
            fill_q    <= fill_d;
        end
    end
`else
    logic unused_echo;
    assign unused_echo = echo_on ^ s1_echo_q;

    always_comb begin
        out_valid_d  = s1_v_q;
        out_sample_d = s1_v_q ? fx : out_sample_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;

endmodule

// File: tb/tb_pedal_fx_core.sv
// Self-checking bench for pedal_fx_core: vector table plus scoreboard.
module tb_pedal_fx_core;

`ifdef PEDAL_ECHO_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              in_valid;
    logic signed [7:0] in_sample;
    logic [1:0]        mode;
    logic [3:0]        level;
    logic [3:0]        rate;
    logic              echo_on;
    logic              out_valid;
    logic signed [7:0] out_sample;

    pedal_fx_core #(.DATA_W(8), .LFO_W(16), .DELAY_DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .mode       (mode),
        .level      (level),
        .rate       (rate),
        .echo_on    (echo_on),
        .out_valid  (out_valid),
        .out_sample (out_sample)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] exp;
        int                due;
    } sb_t;

    typedef struct {
        logic [1:0]        m;
        logic [3:0]        lv;
        logic signed [7:0] s;
        logic signed [7:0] e;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[14];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ov_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        sb_t f;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            f = sb.pop_front();
            n_cmp++; n_err++;
            $display("FAIL missing_out: got none want %0d due %0d now %0d",
                     f.exp, f.due, cyc);
        end
        if (out_valid) begin
            ov_seen++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got %0d at %0d want none",
                         out_sample, cyc);
            end else begin
                f = sb.pop_front();
                if (out_sample !== f.exp || f.due != cyc) begin
                    n_err++;
                    $display("FAIL sample: got %0d at %0d want %0d at %0d",
                             out_sample, cyc, f.exp, f.due);
                end
            end
        end
    end

    task automatic send(input logic signed [7:0] s, input logic [1:0] m,
                        input logic [3:0] lv, input logic [3:0] rt,
                        input logic eo, input logic signed [7:0] e,
                        input bit push);
        @(posedge clk); #1;
        in_valid = 1'b1; ena = 1'b1; in_sample = s;
        mode = m; level = lv; rate = rt; echo_on = eo;
        if (push) sb.push_back('{e, cyc + LAT});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        idle(1);
        while (sb.size() > 0 && k < 50) begin
            idle(1);
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ov0;
        logic signed [7:0] v;
        tbl[0]  = '{2'd0, 4'd0,  8'sh35, 8'sh35};
        tbl[1]  = '{2'd1, 4'd0,  8'sd100, 8'sd7};
        tbl[2]  = '{2'd1, 4'd0,  8'sh80, -8'sd7};
        tbl[3]  = '{2'd1, 4'd15, 8'sh80, -8'sd127};
        tbl[4]  = '{2'd1, 4'd15, 8'sd127, 8'sd127};
        tbl[5]  = '{2'd1, 4'd3,  8'sd50, 8'sd31};
        tbl[6]  = '{2'd1, 4'd3,  -8'sd20, -8'sd20};
        tbl[7]  = '{2'd3, 4'd3,  8'sh5F, 8'sh58};
        tbl[8]  = '{2'd3, 4'd15, 8'sh5F, 8'sh00};
        tbl[9]  = '{2'd3, 4'd15, -8'sd1, 8'sh80};
        tbl[10] = '{2'd3, 4'd0,  -8'sd37, -8'sd37};
        tbl[11] = '{2'd2, 4'd0,  8'sh80, 8'sh80};
        tbl[12] = '{2'd2, 4'd0,  8'sd77, 8'sd77};
        tbl[13] = '{2'd0, 4'd9,  -8'sd1, -8'sd1};

        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_sample = '0;
        mode = 2'd0; level = '0; rate = '0; echo_on = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_sample", int'(out_sample), 0);
        #1 rst_n = 1'b1;

        // Tremolo from a fresh LFO, with dropped strobes before the last sample.
        send(8'sd100, 2'd2, 4'd15, 4'd15, 1'b0, 8'sd100, 1'b1);
        for (int i = 0; i < 2040; i++)
            send(8'sd0, 2'd2, 4'd15, 4'd15, 1'b0, 8'sd0, 1'b1);
        drain();
        ov0 = ov_seen;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; ena = 1'b0; in_sample = 8'sd55;
        end
        idle(6);
        chk("ena_low_no_out", ov_seen, ov0);
        send(8'sd100, 2'd2, 4'd15, 4'd15, 1'b0, 8'sd6, 1'b1);
        drain();

        do_reset();
        for (int i = 0; i < 14; i++)
            send(tbl[i].s, tbl[i].m, tbl[i].lv, 4'(i), 1'b0, tbl[i].e, 1'b1);
        for (int i = 0; i < 16; i++) begin
            v = 8'(i * 13 - 100);
            send(v, 2'd0, 4'd0, 4'd0, 1'b0, v, 1'b1);
        end
        drain();
        idle(4);
        chk("hold_sample", int'(out_sample), int'(v));

        ov0 = ov_seen;
        send(8'sd55, 2'd0, 4'd0, 4'd0, 1'b0, 8'sd0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(5);
        @(negedge clk);
        chk("midreset_no_out", ov_seen, ov0);
        chk("midreset_sample", int'(out_sample), 0);

`ifdef PEDAL_ECHO_EN
        do_reset();
        for (int i = 0; i < 129; i++)
            send((i == 0) ? 8'sd64 : 8'sd0, 2'd0, 4'd0, 4'd0, 1'b1,
                 (i == 0) ? 8'sd64 : (i == 64) ? 8'sd32 :
                 (i == 128) ? 8'sd8 : 8'sd0, 1'b1);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
